link_pattern_gen: RTL and testbench

Parametrised traffic source for the fibre link TX data port, running in the TX bit-clock domain. Produces bursts of test data: incrementing count, PRBS-7, PRBS-15 or a fixed word, separated by programmable idle gaps so the TX falls back to comma/idle transmission between bursts. Replaces hand-written counting stimulus with a reusable block for link bring-up, BER soak and idle/reframe testing.

---
 rtl/link_pattern_gen.sv | 210 +++++++++++++++++++++
 tb/tb_link_pattern_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_pattern_gen.sv
// rtl/link_pattern_gen.sv - burst traffic source (count / PRBS-7 / PRBS-15 / fixed) for the link TX data port
//
// Emits bursts of BURST_LEN words separated by GAP_LEN idle cycles while enable is high.
// Ports:
//   clk_bit        TX bit clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   enable         level; start and keep generating bursts
//   mode           00 count, 01 PRBS-7, 10 PRBS-15, 11 fixed word
//   fixed_pattern  word sent in fixed mode
//   read_enable    TX accepts d_out this cycle
//   d_out          data word to TX
//   d_out_valid    d_out valid (high for the whole burst)
//   busy           high in any state other than IDLE
//   burst_done     one-cycle pulse after the last word of a burst is accepted
//   burst_count    completed bursts since reset, wraps
module link_pattern_gen #(
    parameter int W         = 8,
    parameter int BURST_LEN = 256,
    parameter int GAP_LEN   = 16
) (
    input  logic          clk_bit,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  fixed_pattern,
    input  logic          read_enable,
    output logic [W-1:0]  d_out,
    output logic          d_out_valid,
    output logic          busy,
    output logic          burst_done,
    output logic [15:0]   burst_count
);

    localparam int WCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GCW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(BURST_LEN - 1);
    localparam logic [GCW-1:0] LAST_GAP  = GCW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [14:0]    LFSR_SEED = '1;

    generate
        if (W < 4 || W > 16) begin : g_bad_w
            $error("link_pattern_gen: W must be in 4..16");
        end
        if (BURST_LEN < 1) begin : g_bad_burst_len
            $error("link_pattern_gen: BURST_LEN must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [W-1:0]   fix_q, fix_d;
    logic [W-1:0]   cnt_q, cnt_d;       // next word to emit in count mode
    logic [14:0]    lfsr_q, lfsr_d;     // PRBS-7 uses bits [6:0] only
    logic [WCW-1:0] wc_q, wc_d;
    logic [GCW-1:0] gap_q, gap_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           done_q, done_d;
    logic [15:0]    bcount_q, bcount_d;

    logic [1:0]     gen_mode;
    logic [W-1:0]   gen_fix;
    logic [W-1:0]   gen_cnt;
    logic [14:0]    gen_lfsr;
    logic           advance;
    logic [W+14:0]  prbs_res;

    // W LFSR steps in one cycle; the first generated bit lands in the word MSB.
    // Returns {word, next_state}.
    function automatic logic [W+14:0] prbs_advance(input logic [14:0] seed, input logic long_poly);
        logic [14:0]  s;
        logic [W-1:0] w;
        logic         b;
        s = seed;
        w = '0;
        for (int i = W - 1; i >= 0; i--) begin
            b    = long_poly ? (s[14] ^ s[13]) : (s[6] ^ s[5]);
            w[i] = b;
            s    = {s[13:0], b};
        end
        return {w, s};
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fix_d    = fix_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        wc_d     = wc_q;
        gap_d    = gap_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        bcount_d = bcount_q;

        // Generator inputs come from the latched copies except in LOAD, where the
        // first word is built straight from the live mode/pattern and a fresh seed.
        gen_mode = mode_q;
        gen_fix  = fix_q;
        gen_cnt  = cnt_q;
        gen_lfsr = lfsr_q;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mode_d   = mode;
                fix_d    = fixed_pattern;
                wc_d     = '0;
                cnt_d    = '0;
                lfsr_d   = LFSR_SEED;
                gen_mode = mode;
                gen_fix  = fixed_pattern;
                gen_cnt  = '0;
                gen_lfsr = LFSR_SEED;
                advance  = 1'b1;
                state_d  = S_BURST;
            end
            S_BURST: begin
                if (read_enable) begin
                    if (wc_q == LAST_WORD) begin
                        // No advance here so d_out keeps the last word through the gap.
                        done_d   = 1'b1;
                        bcount_d = bcount_q + 16'd1;
                        if (GAP_LEN > 0) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            state_d = enable ? S_LOAD : S_IDLE;
                        end
                    end else begin
                        wc_d    = wc_q + WCW'(1);
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = enable ? S_LOAD : S_IDLE;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        prbs_res = prbs_advance(gen_lfsr, gen_mode == 2'b10);

        if (advance) begin
            case (gen_mode)
                2'b00: begin
                    dout_d = gen_cnt;
                    cnt_d  = gen_cnt + W'(1);
                end
                2'b01, 2'b10: begin
                    dout_d = prbs_res[W+14:15];
                    lfsr_d = prbs_res[14:0];
                end
                default: begin
                    dout_d = gen_fix;
                end
            endcase
        end
    end

    always_ff @(posedge clk_bit) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            fix_q    <= '0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            wc_q     <= '0;
            gap_q    <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            bcount_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            fix_q    <= fix_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            wc_q     <= wc_d;
            gap_q    <= gap_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            bcount_q <= bcount_d;
        end
    end

    assign d_out       = dout_q;
    assign d_out_valid = (state_q == S_BURST);
    assign busy        = (state_q != S_IDLE);
    assign burst_done  = done_q;
    assign burst_count = bcount_q;

endmodule

// File: tb/tb_link_pattern_gen.sv
// tb/tb_link_pattern_gen.sv - scoreboard bench for link_pattern_gen
module tb_link_pattern_gen;

    logic        clk_bit = 1'b0;
    always #5 clk_bit = ~clk_bit;

    logic        rst, enable, read_enable;
    logic [1:0]  mode;
    logic [7:0]  fixed_pattern;
    logic [7:0]  d_out;
    logic        d_out_valid, busy, burst_done;
    logic [15:0] burst_count;

    logic        en0;
    logic [7:0]  d0;
    logic        v0, busy0, done0;
    logic [15:0] cnt0;

    link_pattern_gen #(.W(8), .BURST_LEN(256), .GAP_LEN(16)) dut (
        .clk_bit(clk_bit), .rst(rst), .enable(enable), .mode(mode),
        .fixed_pattern(fixed_pattern), .read_enable(read_enable),
        .d_out(d_out), .d_out_valid(d_out_valid), .busy(busy),
        .burst_done(burst_done), .burst_count(burst_count)
    );

    link_pattern_gen #(.W(8), .BURST_LEN(4), .GAP_LEN(0)) dut0 (
        .clk_bit(clk_bit), .rst(rst), .enable(en0), .mode(2'b00),
        .fixed_pattern(8'h00), .read_enable(1'b1),
        .d_out(d0), .d_out_valid(v0), .busy(busy0),
        .burst_done(done0), .burst_count(cnt0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [14:0] ms;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bit);
        #1;
    endtask

    // Bit-serial reference PRBS: len=7 or 15, 8 bits per word, MSB first.
    task automatic model_word(input int len, inout logic [14:0] s, output logic [7:0] w);
        logic [14:0] mask;
        logic        nb;
        mask = 15'h7FFF >> (15 - len);
        w = 8'h00;
        for (int b = 0; b < 8; b++) begin
            nb = s[len-1] ^ s[len-2];
            s  = {s[13:0], nb} & mask;
            w  = {w[6:0], nb};
        end
    endtask

    task automatic push_prbs(input int len, input int n);
        logic [7:0] w;
        ms = 15'h7FFF;
        for (int k = 0; k < n; k++) begin
            model_word(len, ms, w);
            exp_q.push_back(w);
        end
    endtask

    // Drive read_enable (high once every `period` cycles) until n more words transfer.
    task automatic run_xfers(input int n, input int period);
        int target;
        int cyc;
        target = xfer_cnt + n;
        cyc = 0;
        while (xfer_cnt < target && cyc < 5000) begin
            read_enable = (cyc % period == 0);
            tick();
            cyc++;
        end
        read_enable = 1'b0;
        if (cyc >= 5000) chk("xfer_timeout", xfer_cnt, target);
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks hold under backpressure.
    initial begin : monitor
        logic       hold_prev;
        logic [7:0] d_prev;
        hold_prev = 1'b0;
        d_prev = 8'h00;
        forever begin
            @(negedge clk_bit);
            if (!rst) begin
                if (hold_prev) begin
                    chk("hold_valid", int'(d_out_valid), 1);
                    chk("hold_data", int'(d_out), int'(d_prev));
                end
                if (burst_done) done_cnt++;
                if (d_out_valid && read_enable) begin
                    if (exp_q.size() == 0) chk("unexpected_word", int'(d_out), -1);
                    else chk("word", int'(d_out), int'(exp_q.pop_front()));
                    xfer_cnt++;
                end
            end
            hold_prev = !rst && d_out_valid && !read_enable;
            d_prev = d_out;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic exp_v0[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   exp_d0[10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    logic exp_p0[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin : stim
        int lo;
        rst = 1'b1; enable = 1'b0; read_enable = 1'b0; mode = 2'b00;
        fixed_pattern = 8'h00; en0 = 1'b0;
        repeat (3) tick();
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_valid", int'(d_out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(burst_done), 0);
        chk("rst_count", int'(burst_count), 0);
        rst = 1'b0;
        tick();

        // Count burst, read_enable 1-in-10, with start latency
        for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
        enable = 1'b1;
        tick();
        chk("load_valid", int'(d_out_valid), 0);
        chk("load_busy", int'(busy), 1);
        tick();
        chk("first_valid", int'(d_out_valid), 1);
        chk("first_word", int'(d_out), 0);
        run_xfers(256, 10);
        chk("done_pulse", int'(burst_done), 1);
        chk("count_after_1", int'(burst_count), 1);
        lo = 0;
        while (!d_out_valid && lo < 100) begin
            lo++;
            tick();
        end
        chk("gap_plus_load_cycles", lo, 17);
        chk("done_pulses_1", done_cnt, 1);
        chk("burst2_first", int'(d_out), 0);

        // Second burst: enable dropped at word 100, 7-cycle backpressure
        for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
        run_xfers(100, 1);
        enable = 1'b0;
        repeat (7) tick();
        run_xfers(156, 1);
        chk("count_after_2", int'(burst_count), 2);
        read_enable = 1'b1;
        lo = 0;
        while (busy && lo < 100) begin
            lo++;
            tick();
        end
        read_enable = 1'b0;
        chk("gap_to_idle_cycles", lo, 16);
        chk("idle_valid", int'(d_out_valid), 0);
        chk("done_pulses_2", done_cnt, 2);

        // Reset at word 50 of a count burst
        for (int k = 0; k < 50; k++) exp_q.push_back(8'(k));
        mode = 2'b00;
        enable = 1'b1;
        run_xfers(50, 1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", int'(d_out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(burst_count), 0);
        chk("midrst_done", int'(burst_done), 0);
        rst = 1'b0;
        tick();
        chk("rerun_load_valid", int'(d_out_valid), 0);
        tick();
        chk("rerun_valid", int'(d_out_valid), 1);
        chk("rerun_word0", int'(d_out), 0);
        chk("midrst_no_pulse", done_cnt, 2);

        // PRBS-7, twice with a reset in between
        for (int r = 0; r < 2; r++) begin
            rst = 1'b1;
            mode = 2'b01;
            tick();
            rst = 1'b0;
            push_prbs(7, 64);
            tick();
            tick();
            chk("prbs7_first", int'(d_out), 8'h02);
            run_xfers(64, 1);
        end

        // PRBS-15 burst with ignored mode changes, then a fixed burst
        rst = 1'b1;
        mode = 2'b10;
        tick();
        rst = 1'b0;
        push_prbs(15, 256);
        run_xfers(40, 1);
        mode = 2'b00;
        run_xfers(160, 1);
        mode = 2'b11;
        fixed_pattern = 8'hBC;
        run_xfers(56, 1);
        for (int k = 0; k < 256; k++) exp_q.push_back(8'hBC);
        run_xfers(100, 1);
        fixed_pattern = 8'h55;
        mode = 2'b01;
        enable = 1'b0;
        run_xfers(156, 1);
        read_enable = 1'b1;
        lo = 0;
        while (busy && lo < 100) begin
            lo++;
            tick();
        end
        read_enable = 1'b0;
        chk("done_pulses_final", done_cnt, 4);
        chk("count_final", int'(burst_count), 2);

        // GAP_LEN=0 build: LOAD is the only valid-low cycle between bursts
        en0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gap0_valid", int'(v0), int'(exp_v0[i]));
            chk("gap0_done", int'(done0), int'(exp_p0[i]));
            if (exp_v0[i]) chk("gap0_word", int'(d0), exp_d0[i]);
        end
        chk("gap0_count", int'(cnt0), 1);
        en0 = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
